// File: rtl/muldiv_pkg.sv
// Shared encodings and constants for the iterative multiply/divide unit.
// Imported by muldiv_unit.
package muldiv_pkg;

    localparam int          ITER   = 32;
    localparam int          CNT_W  = $clog2(ITER);
    localparam logic [31:0] DIVZ_Q = 32'hFFFF_FFFF;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_FINISH = 2'd2
    } state_e;

    // Operation context captured at start and consumed by the FINISH sign fix.
    typedef struct packed {
        logic is_div;
        logic neg_ab;   // operand signs differ (signed ops only)
        logic neg_a;    // dividend negative (signed ops only)
        logic divz;     // divisor was zero
    } ctx_t;

    function automatic logic [31:0] mag(input logic [31:0] v, input logic sgn);
        return sgn ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/muldiv_unit.sv
// MIPS-style HI/LO multiply/divide unit: 32-iteration radix-2 shift-add multiply
// and restoring divide sharing one 64-bit shift register, fixed 34-cycle latency.
module muldiv_unit
    import muldiv_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        hi_we,
    input  logic        lo_we,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    state_e            state, state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [63:0]       sr;
    logic [31:0]       opnd;
    ctx_t              ctx;

    logic              go, last, is_signed, sa, sb;
    logic [32:0]       mul_sum, div_pr, div_diff;
    logic              div_ge;
    logic [63:0]       mul_nxt, div_nxt, prod_fix;
    logic [31:0]       q_fix, r_fix;

    assign go        = (state == ST_IDLE) && start;
    assign last      = (cnt == CNT_W'(ITER - 1));
    assign is_signed = (op == OP_MULT) || (op == OP_DIV);
    assign sa        = is_signed & a[31];
    assign sb        = is_signed & b[31];

    // FSM
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        case (state)
            ST_IDLE:   if (start) state_nxt = ST_RUN;
            ST_RUN: begin
                busy = 1'b1;
                if (last) state_nxt = ST_FINISH;
            end
            ST_FINISH: begin
                busy      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // Multiply step: sr = {acc_hi, multiplier}; add magnitude then shift right.
    assign mul_sum = {1'b0, sr[63:32]} + (sr[0] ? {1'b0, opnd} : 33'd0);
    assign mul_nxt = {mul_sum, sr[31:1]};

    // Divide step: sr = {remainder, dividend/quotient}; shift left and trial-subtract.
    assign div_pr   = {sr[63:32], sr[31]};
    assign div_ge   = (div_pr >= {1'b0, opnd});
    assign div_diff = div_pr - {1'b0, opnd};
    assign div_nxt  = {(div_ge ? div_diff[31:0] : div_pr[31:0]), sr[30:0], div_ge};

    // Sign fix; a zero divisor leaves |a| in the remainder, so hi becomes a itself.
    assign prod_fix = ctx.neg_ab ? (~sr + 64'd1) : sr;
    assign q_fix    = ctx.divz   ? DIVZ_Q
                    : ctx.neg_ab ? (~sr[31:0] + 32'd1) : sr[31:0];
    assign r_fix    = ctx.neg_a  ? (~sr[63:32] + 32'd1) : sr[63:32];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt  <= '0;
            sr   <= '0;
            opnd <= '0;
            ctx  <= '0;
        end else if (go) begin
            cnt        <= '0;
            sr         <= {32'd0, mag(a, sa)};
            opnd       <= mag(b, sb);
            ctx.is_div <= op[1];
            ctx.neg_ab <= sa ^ sb;
            ctx.neg_a  <= sa;
            ctx.divz   <= (b == 32'd0);
        end else if (state == ST_RUN) begin
            cnt <= cnt + CNT_W'(1);
            sr  <= ctx.is_div ? div_nxt : mul_nxt;
        end
    end

    // HI/LO: results land in FINISH; MTHI/MTLO only when idle and not starting.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hi   <= '0;
            lo   <= '0;
            done <= 1'b0;
        end else begin
            done <= (state == ST_FINISH);
            if (state == ST_FINISH) begin
                if (ctx.is_div) begin
                    hi <= r_fix;
                    lo <= q_fix;
                end else begin
                    hi <= prod_fix[63:32];
                    lo <= prod_fix[31:0];
                end
            end else if (state == ST_IDLE && !start) begin
                if (hi_we) hi <= wdata;
                if (lo_we) lo <= wdata;
            end
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Randomized self-checking bench for muldiv_unit against an arithmetic reference model.
module tb_muldiv_unit;

    localparam logic [1:0] MULT = 2'b00, MULTU = 2'b01, DIV = 2'b10, DIVU = 2'b11;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = '0;
    logic [31:0] a = '0, b = '0, wdata = '0;
    logic        hi_we = 1'b0, lo_we = 1'b0;
    logic        busy, done;
    logic [31:0] hi, lo;

    int          n_chk = 0, n_pass = 0;
    logic [31:0] exp_hi = '0, exp_lo = '0;

    muldiv_unit dut (
        .clk(clk), .reset_n(reset_n), .start(start), .op(op), .a(a), .b(b),
        .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_chk++;
        if (obs === exp_v) n_pass++;
        else $display("FAIL %s: got %h want %h", tag, obs, exp_v);
    endtask

    // Reference: {hi, lo} from plain 64-bit arithmetic.
    function automatic logic [63:0] ref_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        longint      sx, sy, q, r;
        logic [63:0] res;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        case (o)
            MULT:  res = 64'(sx * sy);
            MULTU: res = {32'd0, x} * {32'd0, y};
            DIV: begin
                if (y == 0) res = {x, 32'hFFFF_FFFF};
                else begin
                    q = sx / sy;
                    r = sx % sy;
                    res = {r[31:0], q[31:0]};
                end
            end
            default: begin
                if (y == 0) res = {x, 32'hFFFF_FFFF};
                else        res = {x % y, x / y};
            end
        endcase
        return res;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    // Called at #1 after an edge with the DUT idle; leaves at #1 after the cycle following done.
    task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y, input bit with_mt);
        logic [63:0] r;
        r     = ref_op(o, x, y);
        start = 1'b1; op = o; a = x; b = y;
        hi_we = with_mt; lo_we = with_mt; wdata = $urandom;
        @(posedge clk); #1;
        for (int k = 1; k <= 33; k++) begin
            if (k >= 2 && k <= 30) begin
                start = 1'($urandom_range(0, 1));
                op = 2'($urandom_range(0, 3)); a = $urandom; b = $urandom;
                hi_we = 1'($urandom_range(0, 1)); lo_we = 1'($urandom_range(0, 1));
                wdata = $urandom;
            end else begin
                start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
            end
            @(posedge clk); #1;
            if (k < 33) begin
                chk("busy_run", 64'(busy), 64'd1);
                chk("done_run", 64'(done), 64'd0);
                chk("hilo_hold", {hi, lo}, {exp_hi, exp_lo});
            end else begin
                chk("done_lat", 64'(done), 64'd1);
                chk("busy_end", 64'(busy), 64'd0);
                chk("hi_res", 64'(hi), 64'(r[63:32]));
                chk("lo_res", 64'(lo), 64'(r[31:0]));
            end
        end
        exp_hi = r[63:32];
        exp_lo = r[31:0];
        @(posedge clk); #1;
        chk("done_pulse", 64'(done), 64'd0);
        chk("hilo_after", {hi, lo}, {exp_hi, exp_lo});
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_hilo", {hi, lo}, 64'd0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        run_op(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        chk("multu_max", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
        run_op(MULT, 32'hFFFF_FFFD, 32'd7, 1'b0);
        chk("mult_neg", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
        run_op(DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
        chk("div_neg", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op(DIVU, 32'h0009_0000, 32'h89, 1'b0);
        chk("divu", {hi, lo}, 64'h0000_0027_0000_10D1);
        run_op(DIVU, 32'h0009_0000, 32'd0, 1'b0);
        chk("divu_z", {hi, lo}, 64'h0009_0000_FFFF_FFFF);
        run_op(DIV, 32'hFFFF_FFF9, 32'd0, 1'b1);
        chk("div_z", {hi, lo}, 64'hFFFF_FFF9_FFFF_FFFF);

        // MTHI / MTLO in idle
        hi_we = 1'b1; wdata = 32'h1234_5678;
        @(posedge clk); #1;
        hi_we = 1'b0;
        chk("mthi", {hi, lo}, {32'h1234_5678, exp_lo});
        exp_hi = 32'h1234_5678;
        lo_we = 1'b1; wdata = 32'hCAFE_F00D;
        @(posedge clk); #1;
        lo_we = 1'b0;
        chk("mtlo", {hi, lo}, {exp_hi, 32'hCAFE_F00D});
        exp_lo = 32'hCAFE_F00D;

        // Reset mid-MULTU aborts with no done and cleared hi/lo
        start = 1'b1; op = MULTU; a = $urandom; b = $urandom;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        chk("abort_hilo", {hi, lo}, 64'd0);
        repeat (3) begin
            @(posedge clk); #1;
            chk("abort_nodone", 64'(done), 64'd0);
        end
        reset_n = 1'b1;
        exp_hi = '0; exp_lo = '0;
        @(posedge clk); #1;
        run_op(DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        chk("div_ovf", {hi, lo}, 64'h0000_0000_8000_0000);

        for (int i = 0; i < 40; i++)
            run_op(2'($urandom_range(0, 3)), pick(), pick(), 1'($urandom_range(0, 1)));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 The block SHALL have no parameters; the iteration count is fixed at 32.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request a new operation; sampled only in IDLE.
REQ-005 op  input  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-006 a  input  32  multiplicand or dividend (rs).
REQ-007 b  input  32  multiplier or divisor (rt).
REQ-008 hi_we  input  1  MTHI write strobe.
REQ-009 lo_we  input  1  MTLO write strobe.
REQ-010 wdata  input  32  data for MTHI/MTLO.
REQ-011 busy  output  1  high while an operation is in progress (RUN or FINISH).
REQ-012 done  output  1  one-cycle pulse when hi/lo hold a new result.
REQ-013 hi  output  32  HI register: product[63:32] or remainder.
REQ-014 lo  output  32  LO register: product[31:0] or quotient.

Function
REQ-015 States SHALL be IDLE, RUN and FINISH.
- IDLE->RUN on start.
- RUN->FINISH after 32 iterations.
- FINISH->IDLE unconditionally.
REQ-016 On start in IDLE, a, b and op SHALL be latched; later input changes SHALL NOT affect the result.
REQ-017 RUN SHALL perform exactly one iteration per cycle, with a 5-bit counter from 0 to 31.
- Multiply: radix-2 shift-add on operand magnitudes, 64-bit accumulator.
- Divide: restoring division on magnitudes, 33-bit partial remainder.
REQ-018 Signed ops (MULT, DIV) SHALL use absolute values; the sign fix SHALL be applied in FINISH.
- Product is negated when the operand signs differ.
- Quotient is negated when the operand signs differ.
- Remainder takes the dividend's sign.
REQ-019 Latency SHALL be fixed: start sampled at edge N, then busy high from N+1, hi/lo updated at edge N+33, done high for the cycle after edge N+33 with busy low.
REQ-020 Divide by zero (b==0) SHALL complete with normal latency, giving lo=0xFFFFFFFF and hi=a, for both DIV and DIVU.
REQ-021 DIV of 0x80000000 by 0xFFFFFFFF SHALL give lo=0x80000000 and hi=0x00000000, with no trap.
REQ-022 start while busy SHALL be ignored; it is not queued.
REQ-023 hi_we/lo_we SHALL write wdata to hi/lo only in IDLE with start low; they are ignored otherwise, and start wins when both are asserted together.
REQ-024 hi and lo SHALL keep their previous values throughout RUN; they change only at FINISH or on MTHI/MTLO.
REQ-025 done SHALL never be high for two consecutive cycles.

Reset
REQ-026 While reset_n is low, outputs SHALL be: state IDLE, busy=0, done=0, hi=0, lo=0, counter=0.
REQ-027 Reset asserted mid-operation SHALL abort it with no done pulse and no hi/lo update; the first start after release SHALL behave as from power-up.

Structure
REQ-028 Package muldiv_pkg SHALL hold:
- op encodings (OP_MULT, OP_MULTU, OP_DIV, OP_DIVU);
- the state enum;
- the constant ITER=32;
- the divide-by-zero quotient constant 0xFFFFFFFF.
REQ-029 The block SHALL have no sub-module; the datapath and FSM SHALL sit in one module with a shared 64-bit shift register.

Verification
REQ-030 MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001, done exactly 33 cycles after the start edge.
REQ-031 MULT a=0xFFFFFFFD (-3), b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB; DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-032 DIVU a=0x00090000, b=0x00000089 -> lo=0x000010D1, hi=0x00000027; DIVU b=0 -> lo=0xFFFFFFFF, hi=0x00090000.
REQ-033 Start during busy with different operands -> ignored, first result unchanged, a single done pulse; MTHI 0x12345678 in IDLE -> hi=0x12345678 next cycle, lo unchanged.
REQ-034 reset_n low at cycle 10 of a MULTU -> busy=0, hi=lo=0, no done pulse; after release, a new DIV of 0x80000000 by 0xFFFFFFFF -> lo=0x80000000, hi=0.
